left_shift_pipe: RTL and testbench

Pipelined 32-bit logical left barrel shifter with valid/ready handshakes. It is the left-direction counterpart to the ALU's combinational right shifter. It decomposes the shift into five registered stages (16, 8, 4, 2, 1) so the ALU's shift-left path can run at full clock rate, one result per cycle. It also reports lost-bit and signed-overflow status and carries a caller tag so the issue logic can match results to requests.

---
 rtl/left_shift_pipe.sv | 181 ++++++++++++++++++
 tb/tb_left_shift_pipe.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/left_shift_pipe.sv
// ---------------------------------------------------------------------------
// left_shift_pipe
//
// Pipelined 32-bit logical left barrel shifter. The shift is split into five
// registered stages (16, 8, 4, 2, 1). Each stage shifts combinationally in
// front of its register when its amount bit is set. The pipe gives one result
// per cycle and has a latency of five cycles. It reports whether any 1 bit was
// shifted out (lost_out). It also reports whether the signed result differs
// from data_in * 2^amt (ovf_out). A caller tag travels with each operation.
//
// Handshake: per-stage advance with bubble collapse. The ready chain is
// combinational from out_ready back to in_ready. Valid is purely registered.
//
// Ports
//   clock      in   rising-edge clock
//   reset      in   asynchronous, active-high; empties the pipe
//   in_valid   in   request present on data_in / amt_in / tag_in
//   in_ready   out  stage 1 can accept this cycle
//   data_in    in   32-bit operand
//   amt_in     in   5-bit unsigned shift amount
//   tag_in     in   opaque tag, returned unchanged
//   out_valid  out  result present on the output ports
//   out_ready  in   consumer accepts the result
//   data_out   out  data_in << amt_in, zero filled
//   lost_out   out  a 1 bit was shifted out of bit 31
//   ovf_out    out  signed overflow
//   tag_out    out  tag of the result
// ---------------------------------------------------------------------------
module left_shift_pipe #(
  parameter int TAG_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      data_in,
  input  logic [4:0]       amt_in,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      data_out,
  output logic             lost_out,
  output logic             ovf_out,
  output logic [TAG_W-1:0] tag_out
);

  localparam int N_STAGES = 5;

  // Stage registers, indexed 1..5 (S1 nearest the input).
  logic             v_q    [1:N_STAGES];
  logic [31:0]      data_q [1:N_STAGES];
  logic [4:0]       amt_q  [1:N_STAGES];
  logic             lost_q [1:N_STAGES];
  logic             sign_q [1:N_STAGES];
  logic             mism_q [1:N_STAGES];
  logic [TAG_W-1:0] tag_q  [1:N_STAGES];

  // Values presented to the front of each stage.
  logic             src_v    [1:N_STAGES];
  logic [31:0]      src_data [1:N_STAGES];
  logic [4:0]       src_amt  [1:N_STAGES];
  logic             src_lost [1:N_STAGES];
  logic             src_sign [1:N_STAGES];
  logic             src_mism [1:N_STAGES];
  logic [TAG_W-1:0] src_tag  [1:N_STAGES];

  // Next-state values after this stage's conditional shift.
  logic [31:0]      nxt_data [1:N_STAGES];
  logic             nxt_lost [1:N_STAGES];
  logic             nxt_mism [1:N_STAGES];

  logic             load     [1:N_STAGES];

  // Stage 1 takes the request. Stage k takes stage k-1. The sign is captured
  // once from the original operand and never recomputed.
  always_comb begin
    src_v[1]    = in_valid;
    src_data[1] = data_in;
    src_amt[1]  = amt_in;
    src_lost[1] = 1'b0;
    src_sign[1] = data_in[31];
    src_mism[1] = 1'b0;
    src_tag[1]  = tag_in;
    for (int k = 2; k <= N_STAGES; k++) begin
      src_v[k]    = v_q[k-1];
      src_data[k] = data_q[k-1];
      src_amt[k]  = amt_q[k-1];
      src_lost[k] = lost_q[k-1];
      src_sign[k] = sign_q[k-1];
      src_mism[k] = mism_q[k-1];
      src_tag[k]  = tag_q[k-1];
    end
  end

  // Conditional shift per stage. Bits pushed past bit 31 land in the upper
  // half of a 64-bit intermediate. Those bits feed the lost flag. They also
  // feed the mismatch flag, which is set when any of them differs from the
  // sign. Bits that match the sign are what a signed multiply would discard
  // legitimately.
  always_comb begin
    logic [63:0] wide;
    logic [31:0] out_bits;
    logic [31:0] fill;
    int          sh;
    // NOTE: every combinational output gets a default before any condition,
    // so no path leaves it unassigned and no latch is inferred.
    wide     = '0;
    out_bits = '0;
    fill     = '0;
    sh       = 0;
    for (int k = 1; k <= N_STAGES; k++) begin
      sh       = 1 << (N_STAGES - k);
      wide     = {32'h0, src_data[k]} << sh;
      fill     = src_sign[k] ? ((32'h1 << sh) - 32'h1) : 32'h0;
      out_bits = '0;
      if (src_amt[k][N_STAGES-k]) begin
        nxt_data[k] = wide[31:0];
        out_bits    = wide[63:32];
      end else begin
        nxt_data[k] = src_data[k];
        fill        = '0;
      end
      nxt_lost[k] = src_lost[k] | (|out_bits);
      nxt_mism[k] = src_mism[k] | (|(out_bits ^ fill));
    end
  end

  // Ready chain: a stage may load when it is empty or its contents move on.
  // A bubble anywhere downstream therefore lets the input side advance.
  always_comb begin
    load[N_STAGES] = !v_q[N_STAGES] || out_ready;
    for (int k = N_STAGES - 1; k >= 1; k--) begin
      load[k] = !v_q[k] || load[k+1];
    end
  end

  assign in_ready = load[1];

  // NOTE: all state, including the data fields of every stage, is cleared on
  // reset. This makes the outputs read zero the moment reset asserts.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 1; k <= N_STAGES; k++) begin
        v_q[k]    <= 1'b0;
        data_q[k] <= '0;
        amt_q[k]  <= '0;
        lost_q[k] <= 1'b0;
        sign_q[k] <= 1'b0;
        mism_q[k] <= 1'b0;
        tag_q[k]  <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments let every stage sample the pre-edge
      // value of its upstream neighbour, so the pipe moves exactly one step.
      for (int k = 1; k <= N_STAGES; k++) begin
        if (load[k]) begin
          v_q[k] <= src_v[k];
          // Payload is only sampled when something valid arrives. An emptied
          // stage keeps its stale payload, which nobody observes.
          if (src_v[k]) begin
            data_q[k] <= nxt_data[k];
            amt_q[k]  <= src_amt[k];
            lost_q[k] <= nxt_lost[k];
            sign_q[k] <= src_sign[k];
            mism_q[k] <= nxt_mism[k];
            tag_q[k]  <= src_tag[k];
          end
        end
      end
    end
  end

  assign out_valid = v_q[N_STAGES];
  assign data_out  = data_q[N_STAGES];
  assign lost_out  = lost_q[N_STAGES];
  assign tag_out   = tag_q[N_STAGES];
  // A sign flip in the final result is also an overflow, even when every
  // discarded bit matched the sign.
  assign ovf_out   = mism_q[N_STAGES] | (data_q[N_STAGES][31] ^ sign_q[N_STAGES]);

endmodule

// File: tb/tb_left_shift_pipe.sv
// ---------------------------------------------------------------------------
// tb_left_shift_pipe
//
// Directed testbench for left_shift_pipe. It covers the reset state, single
// operations with hand-computed results, a back-pressure and ordering
// scenario, and reset in the middle of operation.
// ---------------------------------------------------------------------------
module tb_left_shift_pipe;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data_in;
  logic [4:0]  amt_in;
  logic [3:0]  tag_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] data_out;
  logic        lost_out;
  logic        ovf_out;
  logic [3:0]  tag_out;

  int vec_cnt = 0;
  int err_cnt = 0;

  left_shift_pipe #(.TAG_W(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .amt_in    (amt_in),
    .tag_in    (tag_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .lost_out  (lost_out),
    .ovf_out   (ovf_out),
    .tag_out   (tag_out)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Time is one unit after the next rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_outputs_zero(input string where);
    check({where, "_out_valid"}, 32'(out_valid), 32'd0);
    check({where, "_data_out"},  data_out,       32'd0);
    check({where, "_lost_out"},  32'(lost_out),  32'd0);
    check({where, "_ovf_out"},   32'(ovf_out),   32'd0);
    check({where, "_tag_out"},   32'(tag_out),   32'd0);
  endtask

  // Issue one request into an empty pipe with out_ready = 1. Then check the
  // latency and every result field.
  task automatic run_one(input string name, input logic [31:0] d, input logic [4:0] a,
                         input logic [3:0] t, input logic [31:0] exp_d,
                         input logic exp_lost, input logic exp_ovf);
    int lat;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    data_in   = d;
    amt_in    = a;
    tag_in    = t;
    #1;
    check({name, "_in_ready"}, 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    data_in  = '0;
    amt_in   = '0;
    tag_in   = '0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    check({name, "_latency"}, 32'(lat),      32'd5);
    check({name, "_data"},    data_out,      exp_d);
    check({name, "_lost"},    32'(lost_out), 32'(exp_lost));
    check({name, "_ovf"},     32'(ovf_out),  32'(exp_ovf));
    check({name, "_tag"},     32'(tag_out),  32'(t));
    step();
    check({name, "_drained"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int          next_tag;
    int          delivered;
    int          occ;
    logic        prev_stall;
    logic [31:0] prev_data;
    logic [3:0]  prev_tag;
    logic        acc;
    logic        del;

    reset     = 1'b1;
    in_valid  = 1'b0;
    data_in   = '0;
    amt_in    = '0;
    tag_in    = '0;
    out_ready = 1'b0;

    // Reset state.
    #12;
    check_outputs_zero("reset");
    reset = 1'b0;
    #1;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    step();

    // Single operations.
    run_one("amt31",     32'h0000_0001, 5'd31, 4'd3, 32'h8000_0000, 1'b0, 1'b1);
    run_one("amt0",      32'hDEAD_BEEF, 5'd0,  4'd9, 32'hDEAD_BEEF, 1'b0, 1'b0);
    run_one("neg_amt4",  32'hFFFF_FFF0, 5'd4,  4'd5, 32'hFFFF_FF00, 1'b1, 1'b0);
    run_one("sign_flip", 32'h4000_0000, 5'd1,  4'd1, 32'h8000_0000, 1'b0, 1'b1);
    run_one("neg_wrap",  32'h8000_0001, 5'd1,  4'd2, 32'h0000_0002, 1'b1, 1'b1);
    run_one("all_ones",  32'hFFFF_FFFF, 5'd31, 4'd4, 32'h8000_0000, 1'b1, 1'b0);
    run_one("amt8",      32'h1234_5678, 5'd8,  4'd6, 32'h3456_7800, 1'b1, 1'b1);
    run_one("amt16",     32'h0000_ABCD, 5'd16, 4'd7, 32'hABCD_0000, 1'b0, 1'b1);

    // Stall and ordering: 8 back-to-back requests, out_ready low in cycles 3..10.
    next_tag   = 0;
    delivered  = 0;
    occ        = 0;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_tag   = '0;
    for (int c = 0; c < 26; c++) begin
      out_ready = !(c >= 3 && c <= 10);
      in_valid  = (next_tag < 8);
      data_in   = 32'(next_tag);
      amt_in    = 5'(next_tag);
      tag_in    = 4'(next_tag);
      #1;
      // Bubble collapse: input is blocked only when all five stages hold
      // data and the output side is stalled.
      check("stall_in_ready", 32'(in_ready), 32'((occ < 5) || out_ready));
      if (prev_stall) begin
        check("stall_stable_data", data_out,      prev_data);
        check("stall_stable_tag",  32'(tag_out),  32'(prev_tag));
        check("stall_stable_vld",  32'(out_valid), 32'd1);
      end
      if (c >= 11 && delivered < 8)
        check("no_gap", 32'(out_valid), 32'd1);
      acc = in_valid && in_ready;
      del = out_valid && out_ready;
      if (del) begin
        check("order_tag",  32'(tag_out), 32'(delivered));
        check("order_data", data_out,     32'(delivered) << delivered);
        delivered++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = data_out;
      prev_tag   = tag_out;
      if (acc) next_tag++;
      occ = occ + (acc ? 1 : 0) - (del ? 1 : 0);
      step();
    end
    in_valid = 1'b0;
    check("stall_all_delivered", 32'(delivered), 32'd8);
    check("stall_empty", 32'(out_valid), 32'd0);

    // Reset mid-flight: requests in cycles 0 and 1, a third presented in
    // cycle 2 while reset asserts.
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      data_in  = 32'h0000_0100 + 32'(c);
      amt_in   = 5'd2;
      tag_in   = 4'(10 + c);
      if (c == 2) begin
        #2;
        reset = 1'b1;
        #1;
        check_outputs_zero("midreset");
      end else begin
        step();
      end
    end
    in_valid = 1'b0;
    step();
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      check("post_reset_no_result", 32'(out_valid), 32'd0);
    end
    run_one("after_reset", 32'h0000_0003, 5'd3, 4'd8, 32'h0000_0018, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
